// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Holding register for the instruction currently presented to decode.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_buf_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, runs a one-outstanding request/grant/response
// handshake to instruction memory and presents one instruction at a time to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic         kill;
    logic         req_q;
    logic         valid_q;
    fetch_buf_t   ibuf_q;
    logic [31:0]  target;

    assign target = align_word(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            kill    <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            ibuf_q  <= '{instr: NOP_INSTR, pc: 32'h0};
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (redirect)
                        pc <= target;
                    // A grant alongside a redirect belongs to the old pc: mark it for discard.
                    if (imem_gnt) begin
                        state <= WAIT;
                        req_q <= 1'b0;
                        kill  <= redirect;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (redirect || kill) begin
                            state <= REQ;
                            req_q <= 1'b1;
                            if (redirect)
                                pc <= target;
                        end else begin
                            state   <= HOLD;
                            valid_q <= 1'b1;
                            ibuf_q  <= '{instr: imem_rdata, pc: pc};
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                        pc   <= target;
                    end
                end
                HOLD: begin
                    // Redirect wins over pc+4 even when decode accepts in the same cycle.
                    if (redirect || instr_ready) begin
                        state   <= REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        pc      <= redirect ? target : ibuf_q.pc + PC_STEP;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = pc;
    assign instr_valid    = valid_q;
    assign instr          = ibuf_q.instr;
    assign instr_pc       = ibuf_q.pc;
    assign opcode         = ibuf_q.instr[6:0];
    assign instr_pc_plus4 = ibuf_q.pc + PC_STEP;

endmodule
